// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_ctrl
// Brief    : Fetch-stage sequencer owning the PC and IF/ID registers, with
//            branch redirect, hazard hold/flush and saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCwrite,
    input  logic             IFIDwrite,
    input  logic             IFIDflush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [31:0]      r_pc_q;
    logic [31:0]      w_pc_d;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      r_instr_q;
    logic [31:0]      w_instr_d;
    logic [31:0]      r_pc4_q;
    logic [31:0]      w_pc4_d;
    logic             r_valid_q;
    logic             w_valid_d;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] r_flush_cnt_q;
    logic [CNT_W-1:0] w_flush_cnt_d;

    // A taken branch outranks the hazard hold: the hazard unit freezes the
    // PC while the branch sits in EX, so the redirect must still land.
    always_comb begin
        w_pc_plus4 = r_pc_q + 32'd4;
        w_pc_d     = r_pc_q;
        if (branch_taken) begin
            w_pc_d = branch_target;
        end else if (!PCwrite) begin
            w_pc_d = w_pc_plus4;
        end
    end

    always_comb begin
        w_instr_d = r_instr_q;
        w_pc4_d   = r_pc4_q;
        w_valid_d = r_valid_q;
        if (IFIDflush || branch_taken) begin
            w_instr_d = NOP_INSTR;
            w_pc4_d   = 32'd0;
            w_valid_d = 1'b0;
        end else if (!IFIDwrite) begin
            w_instr_d = imem_rdata;
            w_pc4_d   = w_pc_plus4;
            w_valid_d = 1'b1;
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (IFIDwrite && (r_stall_cnt_q != c_cnt_max)) begin
            w_stall_cnt_d = r_stall_cnt_q + c_cnt_one;
        end
        if (IFIDflush && (r_flush_cnt_q != c_cnt_max)) begin
            w_flush_cnt_d = r_flush_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_q        <= RESET_PC;
            r_instr_q     <= NOP_INSTR;
            r_pc4_q       <= 32'd0;
            r_valid_q     <= 1'b0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_pc_q        <= w_pc_d;
            r_instr_q     <= w_instr_d;
            r_pc4_q       <= w_pc4_d;
            r_valid_q     <= w_valid_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign imem_addr   = r_pc_q;
    assign ifid_instr  = r_instr_q;
    assign ifid_pc4    = r_pc4_q;
    assign ifid_valid  = r_valid_q;
    assign stall_count = r_stall_cnt_q;
    assign flush_count = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage_ctrl
// Brief    : Self-checking bench for if_stage_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage_ctrl;

    localparam int          CNT_W = 4;
    localparam int          C_MAX = 15;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP = 32'h0000_0000;

    logic             clk;
    logic             rst_n;
    logic             PCwrite;
    logic             IFIDwrite;
    logic             IFIDflush;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    logic [31:0] salt;
    int          checks;
    int          errors;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    int          m_stall_events;
    int          m_flush_events;

    if_stage_ctrl #(
        .RESET_PC  (C_RESET_PC),
        .CNT_W     (CNT_W),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCwrite       (PCwrite),
        .IFIDwrite     (IFIDwrite),
        .IFIDflush     (IFIDflush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    assign imem_rdata = salt + imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!(PCwrite === 1'b0 && IFIDwrite === 1'b1))
                else $error("illegal hazard combination PCwrite=0 with IFIDwrite=1");
        end
    end

    function automatic logic [CNT_W-1:0] sat(input int n);
        return (n > C_MAX) ? CNT_W'(C_MAX) : CNT_W'(n);
    endfunction

    task automatic model_reset();
        m_pc           = C_RESET_PC;
        m_instr        = C_NOP;
        m_pc4          = 32'd0;
        m_valid        = 1'b0;
        m_stall_events = 0;
        m_flush_events = 0;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic fl,
                         input logic br, input logic [31:0] tgt);
        PCwrite       = pcw;
        IFIDwrite     = ifw;
        IFIDflush     = fl;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    // One clock edge; the model applies the fetch rules to the pre-edge state.
    task automatic step();
        logic [31:0] fetched_pc;
        fetched_pc = m_pc;
        @(posedge clk);
        if (IFIDflush || branch_taken) begin
            m_instr = C_NOP;
            m_pc4   = 32'd0;
            m_valid = 1'b0;
        end else if (!IFIDwrite) begin
            m_instr = salt + fetched_pc;
            m_pc4   = fetched_pc + 32'd4;
            m_valid = 1'b1;
        end
        if (branch_taken)  m_pc = branch_target;
        else if (!PCwrite) m_pc = fetched_pc + 32'd4;
        if (IFIDwrite) m_stall_events++;
        if (IFIDflush) m_flush_events++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        salt  = 32'hAAAA_0000;
        drive(1'bx, 1'bx, 1'bx, 1'bx, 32'hxxxx_xxxx);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (imem_addr !== C_RESET_PC || ifid_instr !== C_NOP || ifid_pc4 !== 32'd0 ||
            ifid_valid !== 1'b0 || stall_count !== 4'd0 || flush_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h instr=%h pc4=%h v=%b st=%0d fl=%0d required %h %h 0 0 0 0",
                     imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_count, flush_count, C_RESET_PC, C_NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_free_run();
        checks++;
        if (imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL free_addr0: got %h required 00000000", imem_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL free_addr%0d: got %h required %h", i, imem_addr, 32'(4 * i));
            end
        end
        checks++;
        if (ifid_instr !== 32'hAAAA_0008 || ifid_pc4 !== 32'd12 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL free_ifid: got instr=%h pc4=%h v=%b required aaaa0008 0000000c 1",
                     ifid_instr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        logic [31:0] held_pc4;
        step();
        held_instr = ifid_instr;
        held_pc4   = ifid_pc4;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        checks++;
        if (imem_addr !== 32'd16 || ifid_instr !== held_instr || ifid_pc4 !== held_pc4 ||
            ifid_valid !== 1'b1 || stall_count !== 4'd1) begin
            errors++;
            $display("FAIL stall_hold: got addr=%h instr=%h pc4=%h v=%b st=%0d required 00000010 %h %h 1 1",
                     imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_count, held_instr, held_pc4);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        checks++;
        if (imem_addr !== 32'd20 || ifid_pc4 !== 32'd20) begin
            errors++;
            $display("FAIL stall_resume: got addr=%h pc4=%h required 00000014 00000014", imem_addr, ifid_pc4);
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        step();
        checks++;
        if (imem_addr !== 32'd20 || ifid_valid !== 1'b0 || flush_count !== 4'd1) begin
            errors++;
            $display("FAIL branch_c1: got addr=%h v=%b fl=%0d required 00000014 0 1", imem_addr, ifid_valid, flush_count);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        step();
        checks++;
        if (imem_addr !== 32'h100 || ifid_valid !== 1'b0 || flush_count !== 4'd2) begin
            errors++;
            $display("FAIL branch_c2: got addr=%h v=%b fl=%0d required 00000100 0 2", imem_addr, ifid_valid, flush_count);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        checks++;
        if (ifid_pc4 !== 32'h104 || ifid_valid !== 1'b1 || ifid_instr !== 32'hAAAA_0100) begin
            errors++;
            $display("FAIL branch_land: got pc4=%h v=%b instr=%h required 00000104 1 aaaa0100",
                     ifid_pc4, ifid_valid, ifid_instr);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        checks++;
        if (imem_addr !== 32'd0 || ifid_pc4 !== 32'd0 || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got addr=%h pc4=%h v=%b required 00000000 00000000 1", imem_addr, ifid_pc4, ifid_valid);
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (20) step();
        checks++;
        if (stall_count !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat: got %0d required 15", stall_count);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        step();
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== C_NOP || ifid_pc4 !== 32'd0 ||
            flush_count !== sat(m_flush_events) || stall_count !== 4'd15) begin
            errors++;
            $display("FAIL flush_over_write: got v=%b instr=%h pc4=%h fl=%0d st=%0d required 0 %h 0 %0d 15",
                     ifid_valid, ifid_instr, ifid_pc4, flush_count, stall_count, C_NOP, sat(m_flush_events));
        end
        repeat (19) step();
        checks++;
        if (flush_count !== 4'd15) begin
            errors++;
            $display("FAIL flush_sat: got %0d required 15", flush_count);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (imem_addr !== C_RESET_PC || ifid_instr !== C_NOP || ifid_pc4 !== 32'd0 ||
            ifid_valid !== 1'b0 || stall_count !== 4'd0 || flush_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h instr=%h pc4=%h v=%b st=%0d fl=%0d required reset values",
                     imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_count, flush_count);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        checks++;
        if (imem_addr !== C_RESET_PC || stall_count !== 4'd0 || flush_count !== 4'd0) begin
            errors++;
            $display("FAIL post_reset: got addr=%h st=%0d fl=%0d required %h 0 0", imem_addr, stall_count, flush_count, C_RESET_PC);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc4 !== C_RESET_PC + 32'd4 || ifid_instr !== salt + C_RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: got v=%b pc4=%h instr=%h required 1 %h %h",
                     ifid_valid, ifid_pc4, ifid_instr, C_RESET_PC + 32'd4, salt + C_RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        for (int i = 0; i < 4; i++) begin
            tgt = 32'h0000_2000 + 32'(i * 32'h40);
            drive(1'b1, 1'b0, 1'b0, 1'b1, tgt);
            step();
            checks++;
            if (imem_addr !== tgt || ifid_valid !== 1'b0 || flush_count !== sat(m_flush_events)) begin
                errors++;
                $display("FAIL back_to_back_%0d: got addr=%h v=%b fl=%0d required %h 0 %0d",
                         i, imem_addr, ifid_valid, flush_count, tgt, sat(m_flush_events));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
    endtask

    task automatic test_random();
        logic pcw;
        logic ifw;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) salt = $urandom;
            pcw = ($urandom_range(0, 2) == 0);
            ifw = pcw & ($urandom_range(0, 1) == 1);
            drive(pcw, ifw, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            step();
            checks++;
            if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc4 !== m_pc4 || ifid_valid !== m_valid ||
                stall_count !== sat(m_stall_events) || flush_count !== sat(m_flush_events)) begin
                errors++;
                $display("FAIL random_%0d: got addr=%h instr=%h pc4=%h v=%b st=%0d fl=%0d required %h %h %h %b %0d %0d",
                         i, imem_addr, ifid_instr, ifid_pc4, ifid_valid, stall_count, flush_count,
                         m_pc, m_instr, m_pc4, m_valid, sat(m_stall_events), sat(m_flush_events));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_wrap();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
